mpa_mips_regf_mp: RTL and testbench

Parametrised multi-port general-purpose register file for the MPA MIPS cores; next generation of the 32x32 two-read/one-write register file. Adds configurable width, depth and port counts, multiple write ports with defined collision priority, a per-register pending scoreboard for pipelined issue, and a saturating counter of illegal writes to register 0. It sits between decode (read and scoreboard ports) and writeback (write ports).

---
 rtl/mpa_regf_pkg.sv | 19 +
 rtl/mpa_regf_rd_port.sv | 50 +++++
 rtl/mpa_mips_regf_mp.sv | 92 +++++++++
 tb/tb_mpa_mips_regf_mp.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mpa_regf_pkg.sv
// Shared constants for the MPA MIPS multi-port register file.
// Default sizes, zero-register address, illegal-write counter width, ABI register names.
package mpa_regf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NUM_RD = 2;
  localparam int DEF_NUM_WR = 1;
  localparam int REG_ZERO   = 0;
  localparam int R0_CNT_W   = 8;

  localparam logic [4:0] ZERO = 5'd0,  AT = 5'd1,  V0 = 5'd2,  V1 = 5'd3;
  localparam logic [4:0] A0   = 5'd4,  A1 = 5'd5,  A2 = 5'd6,  A3 = 5'd7;
  localparam logic [4:0] T0   = 5'd8,  T1 = 5'd9,  T2 = 5'd10, T3 = 5'd11;
  localparam logic [4:0] T4   = 5'd12, T5 = 5'd13, T6 = 5'd14, T7 = 5'd15;
  localparam logic [4:0] S0   = 5'd16, S1 = 5'd17, S2 = 5'd18, S3 = 5'd19;
  localparam logic [4:0] S4   = 5'd20, S5 = 5'd21, S6 = 5'd22, S7 = 5'd23;
  localparam logic [4:0] T8   = 5'd24, T9 = 5'd25, K0 = 5'd26, K1 = 5'd27;
  localparam logic [4:0] GP   = 5'd28, SP = 5'd29, FP = 5'd30, RA = 5'd31;
endpackage

// File: rtl/mpa_regf_rd_port.sv
// One combinational read port: decode, zero forcing, pending lookup, and
// (with MPA_REGF_BYPASS_EN) same-cycle write bypass.
module mpa_regf_rd_port import mpa_regf_pkg::*; #(
`ifdef MPA_REGF_BYPASS_EN
  parameter int NUM_WR = DEF_NUM_WR,
`endif
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0]                  ra,
  input  logic [2**ADDR_W-1:0][DATA_W-1:0]   regs,
  input  logic [2**ADDR_W-1:0]               pend,
`ifdef MPA_REGF_BYPASS_EN
  input  logic [NUM_WR-1:0]                  we,
  input  logic [NUM_WR-1:0][ADDR_W-1:0]      wa,
  input  logic [NUM_WR-1:0][DATA_W-1:0]      wd,
  input  logic                               sb_set,
  input  logic [ADDR_W-1:0]                  sb_a,
`endif
  output logic [DATA_W-1:0]                  rd,
  output logic                               rd_pend
);
  logic is_zero;
  assign is_zero = (ra == ADDR_W'(REG_ZERO));

`ifdef MPA_REGF_BYPASS_EN
  logic              hit;
  logic [DATA_W-1:0] byp;

  // Ascending scan so the highest-indexed matching write port wins.
  always_comb begin
    hit = 1'b0;
    byp = '0;
    for (int w = 0; w < NUM_WR; w++)
      if (we[w] && wa[w] == ra) begin
        hit = 1'b1;
        byp = wd[w];
      end
    rd      = hit ? byp : regs[ra];
    rd_pend = hit ? (sb_set && sb_a == ra) : pend[ra];
    if (is_zero) begin
      rd      = '0;
      rd_pend = 1'b0;
    end
  end
`else
  assign rd      = is_zero ? '0 : regs[ra];
  assign rd_pend = !is_zero && pend[ra];
`endif
endmodule

// File: rtl/mpa_mips_regf_mp.sv
// Multi-port MIPS GPR file with pending scoreboard, write-collision flag and
// saturating r0-write counter. Optional macro: MPA_REGF_BYPASS_EN.
module mpa_mips_regf_mp import mpa_regf_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = DEF_NUM_RD,
  parameter int NUM_WR = DEF_NUM_WR
) (
  input  logic                       CLK,
  input  logic                       HW_RSTn,
  input  logic [NUM_RD*ADDR_W-1:0]   RA,
  output logic [NUM_RD*DATA_W-1:0]   RD,
  output logic [NUM_RD-1:0]          RD_PEND,
  input  logic [NUM_WR-1:0]          WE,
  input  logic [NUM_WR*ADDR_W-1:0]   WA,
  input  logic [NUM_WR*DATA_W-1:0]   WD,
  input  logic                       SB_SET,
  input  logic [ADDR_W-1:0]          SB_A,
  output logic                       WR_COLL,
  output logic [R0_CNT_W-1:0]        R0_WR_CNT,
  input  logic                       R0_CNT_CLR
);
  localparam int DEPTH = 2**ADDR_W;

  logic [DEPTH-1:0][DATA_W-1:0]   regs;
  logic [DEPTH-1:0]               pend;
  logic [NUM_WR-1:0][ADDR_W-1:0]  wa;
  logic [NUM_WR-1:0][DATA_W-1:0]  wd;
  logic                           coll;
  logic [2:0]                     n0;
  logic [R0_CNT_W:0]              cnt_sum;
  logic [R0_CNT_W-1:0]            cnt_nxt;

  assign wa = WA;
  assign wd = WD;

  always_comb begin
    coll = 1'b0;
    n0   = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (WE[i] && wa[i] == '0) n0 = n0 + 3'd1;
      for (int j = i + 1; j < NUM_WR; j++)
        if (WE[i] && WE[j] && wa[i] == wa[j] && wa[i] != '0) coll = 1'b1;
    end
  end

  assign cnt_sum = {1'b0, R0_WR_CNT} + {{(R0_CNT_W-2){1'b0}}, n0};
  assign cnt_nxt = cnt_sum[R0_CNT_W] ? '1 : cnt_sum[R0_CNT_W-1:0];

  // Later ports overwrite earlier ones; a scoreboard set lands after the
  // write-clears so a new producer supersedes a same-cycle writeback.
  always_ff @(posedge CLK or negedge HW_RSTn) begin
    if (!HW_RSTn) begin
      regs      <= '0;
      pend      <= '0;
      WR_COLL   <= 1'b0;
      R0_WR_CNT <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++)
        if (WE[w] && wa[w] != '0) begin
          regs[wa[w]] <= wd[w];
          pend[wa[w]] <= 1'b0;
        end
      if (SB_SET && SB_A != '0) pend[SB_A] <= 1'b1;
      WR_COLL   <= coll;
      R0_WR_CNT <= R0_CNT_CLR ? '0 : cnt_nxt;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    mpa_regf_rd_port #(
`ifdef MPA_REGF_BYPASS_EN
      .NUM_WR (NUM_WR),
`endif
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
    ) u_rd (
      .ra      (RA[p*ADDR_W +: ADDR_W]),
      .regs    (regs),
      .pend    (pend),
`ifdef MPA_REGF_BYPASS_EN
      .we      (WE),
      .wa      (wa),
      .wd      (wd),
      .sb_set  (SB_SET),
      .sb_a    (SB_A),
`endif
      .rd      (RD[p*DATA_W +: DATA_W]),
      .rd_pend (RD_PEND[p])
    );
  end
endmodule

// File: tb/tb_mpa_mips_regf_mp.sv
// Directed bench for mpa_mips_regf_mp (NUM_WR=2): array-based reference model
// checked every negedge, plus hand-computed literal expectations.
module tb_mpa_mips_regf_mp;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [9:0]  ra = '0;
  logic [63:0] rd;
  logic [1:0]  rd_pend;
  logic [1:0]  we = '0;
  logic [9:0]  wa = '0;
  logic [63:0] wd = '0;
  logic        sb_set = 1'b0;
  logic [4:0]  sb_a = '0;
  logic        wr_coll;
  logic [7:0]  r0_cnt;
  logic        r0_clr = 1'b0;

  int errs = 0;
  int checks = 0;

  mpa_mips_regf_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .NUM_WR(2)) dut (
    .CLK(clk), .HW_RSTn(rst_n), .RA(ra), .RD(rd), .RD_PEND(rd_pend),
    .WE(we), .WA(wa), .WD(wd), .SB_SET(sb_set), .SB_A(sb_a),
    .WR_COLL(wr_coll), .R0_WR_CNT(r0_cnt), .R0_CNT_CLR(r0_clr)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [31:0] mregs [32] = '{default: '0};
  logic        mpend [32] = '{default: 1'b0};
  logic        mcoll = 1'b0;
  int          mcnt  = 0;
  int          hits [32];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int a = 0; a < 32; a++) begin mregs[a] = '0; mpend[a] = 1'b0; end
      mcoll = 1'b0;
      mcnt  = 0;
    end else begin
      int n0;
      n0 = 0;
      for (int a = 0; a < 32; a++) hits[a] = 0;
      for (int w = 0; w < 2; w++)
        if (we[w]) begin
          if (wa[w*5 +: 5] == 5'd0) n0++;
          else hits[wa[w*5 +: 5]]++;
        end
      mcoll = 1'b0;
      for (int a = 1; a < 32; a++) if (hits[a] >= 2) mcoll = 1'b1;
      for (int w = 0; w < 2; w++)
        if (we[w] && wa[w*5 +: 5] != 5'd0) begin
          mregs[wa[w*5 +: 5]] = wd[w*32 +: 32];
          mpend[wa[w*5 +: 5]] = 1'b0;
        end
      if (sb_set && sb_a != 5'd0) mpend[sb_a] = 1'b1;
      if (r0_clr) mcnt = 0;
      else mcnt = (mcnt + n0 > 255) ? 255 : mcnt + n0;
    end
  end

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    logic [31:0] v;
    v = (a == 5'd0) ? 32'd0 : mregs[a];
`ifdef MPA_REGF_BYPASS_EN
    for (int w = 0; w < 2; w++)
      if (we[w] && wa[w*5 +: 5] == a && a != 5'd0) v = wd[w*32 +: 32];
`endif
    return v;
  endfunction

  function automatic logic exp_pend(input logic [4:0] a);
    logic v;
    v = (a == 5'd0) ? 1'b0 : mpend[a];
`ifdef MPA_REGF_BYPASS_EN
    for (int w = 0; w < 2; w++)
      if (we[w] && wa[w*5 +: 5] == a && a != 5'd0) v = sb_set && sb_a == a;
`endif
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      chk($sformatf("model_rd%0d", p), rd[p*32 +: 32], exp_rd(ra[p*5 +: 5]));
      chk($sformatf("model_pend%0d", p), {31'd0, rd_pend[p]}, {31'd0, exp_pend(ra[p*5 +: 5])});
    end
    chk("model_coll", {31'd0, wr_coll}, {31'd0, mcoll});
    chk("model_cnt", {24'd0, r0_cnt}, mcnt);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic idle;
    we = '0; wa = '0; wd = '0; sb_set = 1'b0; sb_a = '0; r0_clr = 1'b0;
  endtask

  initial begin
    idle();
    ra = {5'd3, 5'd5};
    tick(); tick();
    #1;
    chk("rst_rd", rd[31:0] | rd[63:32], 32'd0);
    chk("rst_pend", {30'd0, rd_pend}, 32'd0);
    chk("rst_cnt", {24'd0, r0_cnt}, 32'd0);
    chk("rst_coll", {31'd0, wr_coll}, 32'd0);
    rst_n = 1'b1;

    // Two ports to address 5: port 1 wins, collision flagged for one cycle
    tick();
    we = 2'b11; wa = {5'd5, 5'd5}; wd = {32'hBBBB_0000, 32'hAAAA_0000};
    tick();
    idle(); ra = {5'd0, 5'd5};
    #1;
    chk("coll_rd", rd[31:0], 32'hBBBB_0000);
    chk("coll_flag", {31'd0, wr_coll}, 32'd1);
    tick();
    #1;
    chk("coll_flag_drop", {31'd0, wr_coll}, 32'd0);

    // Distinct addresses on both ports: no collision
    we = 2'b11; wa = {5'd11, 5'd10}; wd = {32'h0000_0B0B, 32'h0000_0A0A};
    tick();
    idle(); ra = {5'd11, 5'd10};
    #1;
    chk("dual_rd0", rd[31:0], 32'h0000_0A0A);
    chk("dual_rd1", rd[63:32], 32'h0000_0B0B);
    chk("dual_coll", {31'd0, wr_coll}, 32'd0);

    // Writes to r0: 1 + 1 + 2 = 4
    we = 2'b01; wa = '0; wd = {32'd0, 32'hDEAD_BEEF};
    tick();
    tick();
    we = 2'b11; wd = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    tick();
    idle(); ra = '0;
    #1;
    chk("r0_rd", rd[31:0], 32'd0);
    chk("r0_cnt4", {24'd0, r0_cnt}, 32'd4);
    we = 2'b11; wa = '0; wd = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
    for (int i = 0; i < 130; i++) tick();
    idle();
    #1;
    chk("r0_sat", {24'd0, r0_cnt}, 32'd255);
    we = 2'b11; r0_clr = 1'b1;
    tick();
    idle();
    #1;
    chk("r0_clr", {24'd0, r0_cnt}, 32'd0);

    // Scoreboard
    sb_set = 1'b1; sb_a = 5'd9;
    tick();
    idle(); ra = {5'd0, 5'd9};
    #1;
    chk("sb_set", {30'd0, rd_pend}, 32'd1);
    we = 2'b01; wa = {5'd0, 5'd9}; wd = {32'd0, 32'h0000_0099};
    tick();
    idle();
    #1;
    chk("sb_clr", {30'd0, rd_pend}, 32'd0);
    chk("sb_clr_rd", rd[31:0], 32'h0000_0099);
    we = 2'b10; wa = {5'd9, 5'd0}; wd = {32'h0000_0999, 32'd0};
    sb_set = 1'b1; sb_a = 5'd9;
    tick();
    idle();
    #1;
    chk("sb_wins", {30'd0, rd_pend}, 32'd1);
    chk("sb_wins_rd", rd[31:0], 32'h0000_0999);

    // Same-cycle read of a register being written
    ra = {5'd7, 5'd9};
    we = 2'b01; wa = {5'd0, 5'd7}; wd = {32'd0, 32'h0000_1234};
    #1;
`ifdef MPA_REGF_BYPASS_EN
    chk("byp_same", rd[63:32], 32'h0000_1234);
`else
    chk("byp_same", rd[63:32], 32'd0);
`endif
    tick();
    idle();
    #1;
    chk("byp_next", rd[63:32], 32'h0000_1234);

    // Reset between edges clears state immediately, in-flight write lost
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h0000_0055};
    tick();
    idle(); ra = {5'd9, 5'd3};
    #1;
    chk("pre_rst_rd", rd[31:0], 32'h0000_0055);
    chk("pre_rst_pend", {30'd0, rd_pend}, 32'd2);
    we = 2'b01; wa = {5'd0, 5'd3}; wd = {32'd0, 32'h0000_0066};
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rd", rd[31:0], 32'd0);
    chk("mid_rst_pend", {30'd0, rd_pend}, 32'd0);
    tick();
    idle();
    rst_n = 1'b1;
    tick();
    #1;
    chk("post_rst_rd", rd[31:0], 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
